// File: rtl/emmc_ddr_rx_packer.sv
// eMMC 8-bit DDR receive packer: start-bit detect, 32-bit word packing,
// 16 per-line/per-edge CRC16 checks and end-bit check for one block per rx_start.
module emmc_ddr_rx_packer #(
  parameter int unsigned BLK_W     = 12,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           iddr_Q1,
  input  logic [7:0]           iddr_Q2,
  input  logic                 rx_start,
  input  logic [BLK_W-1:0]     blk_size,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 fifo_full,
  output logic [31:0]          fifo_data_out,
  output logic                 fifo_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic                 end_err,
  output logic                 overflow,
  output logic                 timeout
);

  localparam int unsigned CNT_W = BLK_W - 1;
  localparam int unsigned CRC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        blk_half;
  logic [CNT_W-1:0]        dcnt;
  logic [TIMEOUT_W-1:0]    tmo_lim;
  logic [TIMEOUT_W-1:0]    tmo_cnt;
  logic [15:0]             word_hi;
  logic [7:0][CRC_W-1:0]   crc_r;
  logic [7:0][CRC_W-1:0]   crc_f;
  logic                    crc_bad;

  logic [CNT_W-1:0]        blk_half_c;
  logic [7:0]              msb_r_c;
  logic [7:0]              msb_f_c;
  logic                    crc_mis_c;

  // One serial step of CRC16-CCITT (x^16+x^12+x^5+1).
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic b);
    logic [CRC_W-1:0] nxt;
    nxt = {crc[CRC_W-2:0], 1'b0};
    if (crc[CRC_W-1] ^ b) nxt = nxt ^ 16'h1021;
    return nxt;
  endfunction

  // Data cycles per block = bytes/2, with the two low size bits forced to zero.
  assign blk_half_c = CNT_W'((blk_size & ~BLK_W'(3)) >> 1);

  always_comb begin
    msb_r_c = '0;
    msb_f_c = '0;
    for (int i = 0; i < 8; i++) begin
      msb_r_c[i] = crc_r[i][CRC_W-1];
      msb_f_c[i] = crc_f[i][CRC_W-1];
    end
    crc_mis_c = (|(msb_r_c ^ iddr_Q1)) | (|(msb_f_c ^ iddr_Q2));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      blk_half      <= '0;
      dcnt          <= '0;
      tmo_lim       <= '0;
      tmo_cnt       <= '0;
      word_hi       <= '0;
      crc_r         <= '0;
      crc_f         <= '0;
      crc_bad       <= 1'b0;
      fifo_data_out <= '0;
      fifo_wr_en    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      crc_err       <= 1'b0;
      end_err       <= 1'b0;
      overflow      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_start) begin
            state    <= S_WAIT;
            busy     <= 1'b1;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            blk_half <= blk_half_c;
            tmo_lim  <= timeout_val;
            tmo_cnt  <= '0;
            dcnt     <= '0;
            crc_r    <= '0;
            crc_f    <= '0;
            crc_bad  <= 1'b0;
          end
        end

        S_WAIT: begin
          if (iddr_Q1 == 8'h00 && iddr_Q2 == 8'h00) begin
            state <= S_DATA;
          end else if (tmo_lim != '0 && (tmo_cnt + TIMEOUT_W'(1)) == tmo_lim) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end

        S_DATA: begin
          for (int i = 0; i < 8; i++) begin
            crc_r[i] <= crc_step(crc_r[i], iddr_Q1[i]);
            crc_f[i] <= crc_step(crc_f[i], iddr_Q2[i]);
          end
          // Even cycle holds the upper half; odd cycle completes and emits the word.
          if (!dcnt[0]) begin
            word_hi <= {iddr_Q1, iddr_Q2};
          end else if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            fifo_wr_en    <= 1'b1;
            fifo_data_out <= {word_hi, iddr_Q1, iddr_Q2};
          end
          if (dcnt == blk_half - CNT_W'(1)) begin
            dcnt  <= '0;
            state <= S_CRC;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
          end
        end

        S_CRC: begin
          if (crc_mis_c) crc_bad <= 1'b1;
          for (int i = 0; i < 8; i++) begin
            crc_r[i] <= {crc_r[i][CRC_W-2:0], 1'b0};
            crc_f[i] <= {crc_f[i][CRC_W-2:0], 1'b0};
          end
          if (dcnt == CNT_W'(CRC_W - 1)) begin
            dcnt  <= '0;
            state <= S_END;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
          end
        end

        S_END: begin
          end_err <= !(iddr_Q1 == 8'hFF && iddr_Q2 == 8'hFF);
          crc_err <= crc_bad;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_ddr_rx_packer.sv
// Scoreboard bench for emmc_ddr_rx_packer: random blocks against a byte-level
// reference model, plus directed timeout and mid-block reset scenarios.
module tb_emmc_ddr_rx_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  iddr_Q1, iddr_Q2;
  logic        rx_start;
  logic [11:0] blk_size;
  logic [23:0] timeout_val;
  logic        fifo_full;
  logic [31:0] fifo_data_out;
  logic        fifo_wr_en, busy, done, crc_err, end_err, overflow, timeout;

  typedef struct packed {
    logic crc;
    logic end_e;
    logic ovf;
    logic tmo;
  } status_t;

  logic [31:0] exp_words[$];
  status_t     exp_st[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  emmc_ddr_rx_packer #(.BLK_W(12), .TIMEOUT_W(24)) dut (
    .clock(clock), .reset(reset), .iddr_Q1(iddr_Q1), .iddr_Q2(iddr_Q2),
    .rx_start(rx_start), .blk_size(blk_size), .timeout_val(timeout_val),
    .fifo_full(fifo_full), .fifo_data_out(fifo_data_out), .fifo_wr_en(fifo_wr_en),
    .busy(busy), .done(done), .crc_err(crc_err), .end_err(end_err),
    .overflow(overflow), .timeout(timeout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference CRC16-CCITT over a bit stream, MSB-first shift register.
  function automatic logic [15:0] crc_bit(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    crc = crc << 1;
    if (fb) crc = crc ^ 16'h1021;
    return crc;
  endfunction

  // Monitor: pops expectations whenever the DUT writes or finishes.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (fifo_wr_en) begin
        if (exp_words.size() == 0) check("unexpected_write", fifo_data_out, 32'hx);
        else check("fifo_word", fifo_data_out, exp_words.pop_front());
      end
      if (done) begin
        check("done_with_busy", 32'(busy), 32'd0);
        if (exp_st.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else check("status", 32'({crc_err, end_err, overflow, timeout}), 32'(exp_st.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {fifo_data_out}, 32'd0);
    check({nm, "_flags"}, 32'({fifo_wr_en, busy, done, crc_err, end_err, overflow, timeout}), 32'd0);
  endtask

  // mode: 0 random bytes, 1 incrementing bytes, 2 fixed 12 34 56 78.
  // flip_line < 0 means no CRC corruption; reset_at < 0 means no mid-block reset.
  task automatic run_block(input int bsz_raw, input int mode, input int drop_pct,
                           input int flip_line, input bit flip_fall, input bit end_bad,
                           input int reset_at);
    int nb, h, w, nwords, flip_j;
    logic [7:0]  data[];
    bit          drop[];
    logic [15:0] cr[8];
    logic [15:0] cf[8];
    bit          any_drop;
    bit          found;
    nb = bsz_raw & ~3;
    h = nb / 2;
    nwords = nb / 4;
    data = new[nb];
    drop = new[nwords];
    any_drop = 0;
    for (int b = 0; b < nb; b++) begin
      if (mode == 1) data[b] = 8'(b);
      else if (mode == 2) data[b] = 8'(8'h12 + 8'h22 * b);
      else data[b] = 8'($urandom_range(255));
    end
    for (int k = 0; k < nwords; k++) begin
      drop[k] = (reset_at < 0) && ($urandom_range(99) < drop_pct);
      any_drop |= drop[k];
    end
    for (int i = 0; i < 8; i++) begin cr[i] = '0; cf[i] = '0; end
    for (int c = 0; c < h; c++)
      for (int i = 0; i < 8; i++) begin
        cr[i] = crc_bit(cr[i], data[2*c][i]);
        cf[i] = crc_bit(cf[i], data[2*c+1][i]);
      end
    for (int k = 0; k < nwords; k++) begin
      logic [31:0] wd;
      wd = {data[4*k], data[4*k+1], data[4*k+2], data[4*k+3]};
      if (reset_at >= 0) begin
        if (2*k + 1 < reset_at) exp_words.push_back(wd);
      end else if (!drop[k]) exp_words.push_back(wd);
    end
    if (reset_at < 0) exp_st.push_back(status_t'({flip_line >= 0, end_bad, any_drop, 1'b0}));

    w = $urandom_range(5);
    tick();
    rx_start = 1'b1;
    blk_size = 12'(bsz_raw);
    timeout_val = ($urandom_range(1) == 1) ? 24'(w + 1 + $urandom_range(20)) : 24'd0;
    iddr_Q1 = 8'h5A; iddr_Q2 = 8'hA5;
    tick();
    rx_start = 1'b0;
    for (int n = 0; n < w; n++) begin
      iddr_Q1 = 8'($urandom_range(1, 255));
      iddr_Q2 = 8'($urandom_range(255));
      if (n == 0) begin rx_start = 1'b1; blk_size = 12'd8; end
      tick();
      rx_start = 1'b0;
    end
    iddr_Q1 = 8'h00; iddr_Q2 = 8'h00;
    for (int c = 0; c < h; c++) begin
      tick();
      iddr_Q1 = data[2*c];
      iddr_Q2 = data[2*c+1];
      fifo_full = (c >= 1) ? drop[(c-1)/2] : 1'b0;
      if (c == reset_at) begin
        reset = 1'b0;
        tick();
        check_all_zero("reset_mid_block");
        reset = 1'b1;
        fifo_full = 1'b0;
        return;
      end
    end
    flip_j = $urandom_range(15);
    for (int j = 0; j < 16; j++) begin
      tick();
      fifo_full = (j == 0) ? drop[(h-1)/2] : 1'b0;
      for (int i = 0; i < 8; i++) begin
        iddr_Q1[i] = cr[i][15-j] ^ (flip_line == i && !flip_fall && j == flip_j);
        iddr_Q2[i] = cf[i][15-j] ^ (flip_line == i && flip_fall && j == flip_j);
      end
    end
    tick();
    iddr_Q1 = end_bad ? 8'($urandom_range(254)) : 8'hFF;
    iddr_Q2 = 8'hFF;
    found = 0;
    for (int n = 0; n < 4 && !found; n++) begin
      tick();
      found = done;
    end
    check("done_seen", 32'(found), 32'd1);
    iddr_Q1 = 8'h33; iddr_Q2 = 8'h44;
    tick();
    check("flags_held", 32'({crc_err, end_err, overflow}), 32'({flip_line >= 0, end_bad, any_drop}));
  endtask

  task automatic run_timeout(input int t);
    int n;
    bit found;
    exp_st.push_back(status_t'(4'b0001));
    tick();
    rx_start = 1'b1;
    blk_size = 12'd16;
    timeout_val = 24'(t);
    tick();
    rx_start = 1'b0;
    found = 0;
    n = 0;
    while (!found && n < t + 20) begin
      iddr_Q1 = 8'($urandom_range(1, 255));
      iddr_Q2 = 8'($urandom_range(255));
      tick();
      n++;
      found = done;
    end
    check("timeout_cycles", 32'(n), 32'(t));
    check("timeout_flag", 32'(timeout), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    rx_start = 1'b0;
    blk_size = '0;
    timeout_val = '0;
    iddr_Q1 = 8'hFF;
    iddr_Q2 = 8'hFF;
    fifo_full = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset = 1'b1;
    tick();

    run_block(4, 2, 0, -1, 1'b0, 1'b0, -1);
    run_block(512, 1, 0, -1, 1'b0, 1'b0, -1);
    run_block(512, 1, 0, 3, 1'b1, 1'b0, -1);
    run_block(16, 0, 100, -1, 1'b0, 1'b0, -1);
    run_timeout(100);
    run_block(16, 0, 0, -1, 1'b0, 1'b0, 3);
    run_block(8, 0, 0, -1, 1'b0, 1'b0, -1);
    run_block(4, 0, 0, -1, 1'b0, 1'b1, -1);
    for (int r = 0; r < 14; r++) begin
      int fl;
      fl = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
      run_block(int'($urandom_range(1, 16)) * 4 + int'($urandom_range(3)), 0,
                ($urandom_range(1) == 1) ? 30 : 0, fl, 1'($urandom_range(1)),
                ($urandom_range(4) == 0), -1);
    end
    run_timeout(int'($urandom_range(2, 40)));

    repeat (4) tick();
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("status_left", 32'(exp_st.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
